// File: rtl/obi_lsu_pkg.sv
// Shared types and lane helpers for the OBI load/store initiator.
package obi_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      sgn;
    logic [1:0] off;
  } tracker_entry_t;

  function automatic logic is_illegal(lsu_size_e size, logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] be_gen(lsu_size_e size, logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << off;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_replicate(lsu_size_e size, logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      SIZE_BYTE: w = {4{wdata[7:0]}};
      SIZE_HALF: w = {2{wdata[15:0]}};
      default:   w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rdata_format(logic [31:0] rdata, tracker_entry_t e);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {e.off, 3'b000};
    case (e.size)
      SIZE_BYTE: r = {{24{e.sgn & s[7]}}, s[7:0]};
      SIZE_HALF: r = {{16{e.sgn & s[15]}}, s[15:0]};
      default:   r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/obi_lsu_tracker_fifo.sv
// Synchronous FIFO of in-flight transaction descriptors, popped in issue order.
module obi_lsu_tracker_fifo
  import obi_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  tracker_entry_t push_data_i,
  input  logic           pop_i,
  output tracker_entry_t head_o,
  output logic [CntW-1:0] count_o,
  output logic           full_o,
  output logic           empty_o
);

  tracker_entry_t  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/obi_lsu_initiator.sv
// OBI manager: registers core requests into an address phase and formats
// in-order responses using a descriptor FIFO.
module obi_lsu_initiator
  import obi_lsu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic           aph_valid_q;
  logic [31:0]    aph_addr_q, aph_wdata_q;
  logic [3:0]     aph_be_q;
  tracker_entry_t aph_entry_q;
  logic           err_pending_q;

  tracker_entry_t  head;
  logic [CntW-1:0] cnt;
  logic            fifo_full, fifo_empty;
  lsu_size_e       req_size;
  logic            req_err, gnt_fire, rsp_fire, accept;

  assign req_size = lsu_size_e'(req_size_i);
  assign req_err  = is_illegal(req_size, req_addr_i[1:0]);
  assign obi_req_o = aph_valid_q && !fifo_full;
  assign gnt_fire  = obi_req_o && obi_gnt_i;
  // Responses arriving with nothing outstanding are dropped.
  assign rsp_fire  = obi_rvalid_i && !fifo_empty;

  // Error requests only enter an idle pipeline so their response cannot collide.
  assign req_ready_o = !rst_i && !err_pending_q && (!aph_valid_q || gnt_fire) &&
                       (!req_err || (!aph_valid_q && cnt == '0));
  assign accept = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aph_valid_q   <= 1'b0;
      aph_addr_q    <= '0;
      aph_wdata_q   <= '0;
      aph_be_q      <= '0;
      aph_entry_q   <= '0;
      err_pending_q <= 1'b0;
    end else begin
      err_pending_q <= accept && req_err;
      if (accept && !req_err) begin
        aph_valid_q   <= 1'b1;
        aph_addr_q    <= {req_addr_i[31:2], 2'b00};
        aph_wdata_q   <= wdata_replicate(req_size, req_wdata_i);
        aph_be_q      <= be_gen(req_size, req_addr_i[1:0]);
        aph_entry_q   <= '{we: req_we_i, size: req_size, sgn: req_signed_i,
                           off: req_addr_i[1:0]};
      end else if (gnt_fire) begin
        aph_valid_q <= 1'b0;
      end
    end
  end

  obi_lsu_tracker_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (gnt_fire),
    .push_data_i(aph_entry_q),
    .pop_i      (obi_rvalid_i),
    .head_o     (head),
    .count_o    (cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign obi_addr_o  = aph_addr_q;
  assign obi_we_o    = aph_entry_q.we;
  assign obi_be_o    = aph_be_q;
  assign obi_wdata_o = aph_wdata_q;

  assign resp_valid_o = err_pending_q || rsp_fire;
  assign resp_err_o   = err_pending_q;
  assign resp_rdata_o = (rsp_fire && !head.we) ? rdata_format(obi_rdata_i, head) : 32'h0;

endmodule

// File: tb/tb_obi_lsu_initiator.sv
// Directed bench for obi_lsu_initiator with a small in-order OBI memory responder.
module tb_obi_lsu_initiator;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        obi_req_o, obi_we_o;
  logic        obi_gnt_i = 1'b1;
  logic [31:0] obi_addr_o, obi_wdata_o;
  logic [3:0]  obi_be_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;

  always #5 clk = ~clk;

  obi_lsu_initiator #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
  );

  int total = 0;
  int passes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Responder: word memory, responses rsp_lat cycles after grant, in order.
  typedef struct { int due; logic [31:0] data; } pend_t;
  pend_t       pend[$];
  logic [31:0] mem [int];
  int          rsp_lat = 1;
  int          cyc = 0;
  int          out_cnt = 0;

  function automatic logic [31:0] rd_word(int idx);
    return mem.exists(idx) ? mem[idx] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      pend.delete();
      obi_rvalid_i <= 1'b0;
      out_cnt      <= 0;
    end else begin
      if (obi_req_o && obi_gnt_i) begin
        int          idx;
        logic [31:0] w;
        idx = int'(obi_addr_o[31:2]);
        w   = rd_word(idx);
        pend.push_back('{cyc + rsp_lat, w});
        if (obi_we_o) begin
          for (int b = 0; b < 4; b++) if (obi_be_o[b]) w[8*b +: 8] = obi_wdata_o[8*b +: 8];
          mem[idx] = w;
        end
      end
      if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
        obi_rvalid_i <= 1'b1;
        obi_rdata_i  <= pend[0].data;
        pend.pop_front();
      end else begin
        obi_rvalid_i <= 1'b0;
      end
      out_cnt <= out_cnt + ((obi_req_o && obi_gnt_i) ? 1 : 0) - (obi_rvalid_i ? 1 : 0);
    end
    cyc <= cyc + 1;
  end

  // Response monitor, sampled mid-low-phase.
  typedef struct { int n; logic [31:0] rdata; logic err; } rsp_t;
  rsp_t rsp_q[$];
  int   req_log[$];
  int   ncyc = 0;

  always begin
    @(negedge clk);
    #2;
    ncyc++;
    if (resp_valid_o) rsp_q.push_back('{ncyc, resp_rdata_o, resp_err_o});
    if (obi_req_o) req_log.push_back(ncyc);
    if (obi_rvalid_i && !rst_i) check("rvalid_with_nothing_outstanding", 32'(out_cnt != 0), 32'd1);
  end

  typedef struct {
    logic we; logic [31:0] addr; logic [1:0] size; logic sgn; logic [31:0] wdata;
    logic [3:0] be; logic [31:0] obi_wdata; logic err; logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [1:0] size, logic sgn,
                              logic [31:0] wdata, logic [3:0] be, logic [31:0] ow,
                              logic err, logic [31:0] rdata);
    return '{we, addr, size, sgn, wdata, be, ow, err, rdata};
  endfunction

  task automatic drive(logic we, logic [31:0] addr, logic [1:0] size, logic sgn,
                       logic [31:0] wdata);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_size_i = size; req_signed_i = sgn; req_wdata_i = wdata;
  endtask

  task automatic run_vec(string tag, vec_t v);
    int acc_n;
    @(negedge clk);
    drive(v.we, v.addr, v.size, v.sgn, v.wdata);
    #1;
    for (int i = 0; i < 20 && !req_ready_o; i++) begin @(negedge clk); #1; end
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    if (!req_ready_o) begin req_valid_i = 1'b0; return; end
    rsp_q.delete();
    @(posedge clk);
    acc_n = ncyc;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check({tag, "_obi_req"}, 32'(obi_req_o), 32'(!v.err));
    if (!v.err) begin
      check({tag, "_addr"}, obi_addr_o, {v.addr[31:2], 2'b00});
      check({tag, "_be"}, 32'(obi_be_o), 32'(v.be));
      check({tag, "_we"}, 32'(obi_we_o), 32'(v.we));
      if (v.we) check({tag, "_wdata"}, obi_wdata_o, v.obi_wdata);
    end
    #2;
    for (int i = 0; i < 20 && rsp_q.size() == 0; i++) begin @(negedge clk); #3; end
    if (rsp_q.size() == 0) begin
      check({tag, "_resp_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(rsp_q[0].n - acc_n), v.err ? 32'd1 : 32'd2);
      check({tag, "_rdata"}, rsp_q[0].rdata, v.rdata);
      check({tag, "_err"}, 32'(rsp_q[0].err), 32'(v.err));
    end
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = mk(1, 32'h1000, 2'b10, 0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
    vecs[1]  = mk(0, 32'h1000, 2'b10, 0, 32'h0, 4'b1111, 32'h0, 0, 32'hDEADBEEF);
    vecs[2]  = mk(1, 32'h2001, 2'b00, 0, 32'h000000AA, 4'b0010, 32'hAAAAAAAA, 0, 32'h0);
    vecs[3]  = mk(0, 32'h2001, 2'b00, 1, 32'h0, 4'b0010, 32'h0, 0, 32'hFFFFFFAA);
    vecs[4]  = mk(0, 32'h2001, 2'b00, 0, 32'h0, 4'b0010, 32'h0, 0, 32'h000000AA);
    vecs[5]  = mk(1, 32'h2002, 2'b01, 0, 32'h00008001, 4'b1100, 32'h80018001, 0, 32'h0);
    vecs[6]  = mk(0, 32'h2002, 2'b01, 1, 32'h0, 4'b1100, 32'h0, 0, 32'hFFFF8001);
    vecs[7]  = mk(0, 32'h2000, 2'b10, 0, 32'h0, 4'b1111, 32'h0, 0, 32'h8001AA00);
    vecs[8]  = mk(0, 32'h2002, 2'b01, 0, 32'h0, 4'b1100, 32'h0, 0, 32'h00008001);
    vecs[9]  = mk(0, 32'h3002, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0);
    vecs[10] = mk(0, 32'h3001, 2'b01, 1, 32'h0, 4'b0000, 32'h0, 1, 32'h0);
    vecs[11] = mk(1, 32'h3000, 2'b11, 0, 32'h12345678, 4'b0000, 32'h0, 1, 32'h0);
    vecs[12] = mk(0, 32'h2003, 2'b00, 1, 32'h0, 4'b1000, 32'h0, 0, 32'hFFFFFF80);
    vecs[13] = mk(0, 32'h2000, 2'b00, 0, 32'h0, 4'b0001, 32'h0, 0, 32'h00000000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_obi_req", 32'(obi_req_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_resp_err", 32'(resp_err_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("idle_ready", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back stores then loads with grant always high
    rsp_q.delete(); req_log.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 32'h4000 + 32'(4 * i), 2'b10, 0, 32'h11111111 * 32'(i + 1));
      #1; check($sformatf("b2b_st_ready%0d", i), 32'(req_ready_o), 32'd1);
      @(posedge clk);
    end
    @(negedge clk); req_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("b2b_req_cycles", 32'(req_log.size()), 32'd3);
    if (req_log.size() == 3) check("b2b_req_consecutive", 32'(req_log[2] - req_log[0]), 32'd2);
    check("b2b_st_resp_count", 32'(rsp_q.size()), 32'd3);
    rsp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 32'h4000 + 32'(4 * i), 2'b10, 0, 32'h0);
      #1; check($sformatf("b2b_ld_ready%0d", i), 32'(req_ready_o), 32'd1);
      @(posedge clk);
    end
    @(negedge clk); req_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("b2b_ld_resp_count", 32'(rsp_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < rsp_q.size(); i++)
      check($sformatf("b2b_ld_rdata%0d", i), rsp_q[i].rdata, 32'h11111111 * 32'(i + 1));

    // Grant held low, slow responder, outstanding cap of 2
    rsp_lat = 3; obi_gnt_i = 1'b0; rsp_q.delete();
    @(negedge clk);
    drive(1, 32'h5000, 2'b10, 0, 32'h12345678);
    #1; check("stall_a_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 32'h5004, 2'b10, 0, 32'h9ABCDEF0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_req%0d", i), 32'(obi_req_o), 32'd1);
      check($sformatf("stall_addr%0d", i), obi_addr_o, 32'h5000);
      check($sformatf("stall_wdata%0d", i), obi_wdata_o, 32'h12345678);
      check($sformatf("stall_be%0d", i), 32'(obi_be_o), 32'hF);
      check($sformatf("stall_ready%0d", i), 32'(req_ready_o), 32'd0);
      @(negedge clk);
    end
    obi_gnt_i = 1'b1;
    #1; check("stall_b_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 32'h5000, 2'b10, 0, 32'h0);
    #1;
    check("stall_b_addr", obi_addr_o, 32'h5004);
    check("stall_c_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk); req_valid_i = 1'b0; #1;
    check("cap_hold0", 32'(obi_req_o), 32'd0);
    @(negedge clk); #1;
    check("cap_hold1", 32'(obi_req_o), 32'd0);
    check("cap_first_rvalid", 32'(resp_valid_o), 32'd1);
    @(negedge clk); #1;
    check("cap_release", 32'(obi_req_o), 32'd1);
    check("cap_c_addr", obi_addr_o, 32'h5000);
    for (int i = 0; i < 20 && rsp_q.size() < 3; i++) begin @(negedge clk); #3; end
    check("order_count", 32'(rsp_q.size()), 32'd3);
    if (rsp_q.size() == 3) begin
      check("order_a", rsp_q[0].rdata, 32'h0);
      check("order_b", rsp_q[1].rdata, 32'h0);
      check("order_c", rsp_q[2].rdata, 32'h12345678);
    end

    // Reset while a signed byte load is outstanding
    @(negedge clk);
    drive(0, 32'h2001, 2'b00, 1, 32'h0);
    @(posedge clk);
    @(negedge clk); req_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("mid_rst_obi_req", 32'(obi_req_o), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("mid_rst_resp_err", 32'(resp_err_o), 32'd0);
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    rst_i = 1'b0; rsp_lat = 1;
    #1; check("post_rst_ready", 32'(req_ready_o), 32'd1);
    run_vec("post_rst", vecs[1]);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
